// File: rtl/apb_fifo_uart.sv
// 16550-style APB3 UART: byte registers, TX/RX FIFOs, TX valid/ready character port, RX strobe port.
// Zero-latency APB except THR writes to a full TX FIFO, which stall on PREADY when BLOCK_ON_FULL is set.
module apb_fifo_uart #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TX_DEPTH       = 8,
  parameter int RX_DEPTH       = 8,
  parameter int TX_GAP         = 0,
  parameter bit BLOCK_ON_FULL  = 1'b1,
  parameter bit SIM_PRINT      = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      INT,
  output logic                      TX_VALID,
  output logic [7:0]                TX_DATA,
  input  logic                      TX_READY,
  input  logic                      RX_VALID,
  input  logic [7:0]                RX_DATA
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;
  localparam int GW  = $clog2(TX_GAP + 2);

  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic           tx_vld_q, tx_vld_d;
  logic [7:0]     tx_dat_q, tx_dat_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [2:0]     ier_q;
  logic [7:0]     lcr_q, mcr_q, scr_q;
  logic           oe_q, int_q;

  logic [2:0] addr;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       thr_req, tx_pop_ok, acc, wr, rd;
  logic       tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush, oe_set, lsr_rd;
  logic [7:0] lsr, iir, rdata;
  logic       unused_ok;

  assign addr      = PADDR[2:0];
  assign unused_ok = ^{PADDR[APB_ADDR_WIDTH-1:3], PWDATA[31:8]};
  assign tx_empty  = (tx_cnt_q == '0);
  assign tx_full   = (tx_cnt_q == TCW'(TX_DEPTH));
  assign rx_empty  = (rx_cnt_q == '0);
  assign rx_full   = (rx_cnt_q == RCW'(RX_DEPTH));

  // The output register can take the head this cycle; this also frees a slot for a stalled THR write.
  assign tx_pop_ok = !tx_vld_q && (gap_q == '0) && !tx_empty;
  assign thr_req   = PSEL && PENABLE && PWRITE && (addr == 3'd0);
  assign PREADY    = !(BLOCK_ON_FULL && thr_req && tx_full && !tx_pop_ok);
  assign PSLVERR   = 1'b0;

  assign acc      = PSEL && PENABLE && PREADY;
  assign wr       = acc && PWRITE;
  assign rd       = acc && !PWRITE;
  assign tx_flush = wr && (addr == 3'd2) && PWDATA[2];
  assign rx_flush = wr && (addr == 3'd2) && PWDATA[1];
  assign lsr_rd   = rd && (addr == 3'd5);

  assign tx_pop  = tx_pop_ok && !tx_flush;
  assign tx_push = wr && (addr == 3'd0) && (!tx_full || tx_pop);
  assign rx_pop  = rd && (addr == 3'd0) && !rx_empty;
  assign rx_push = RX_VALID && (!rx_full || rx_pop) && !rx_flush;
  assign oe_set  = RX_VALID && rx_full && !rx_pop;

  assign lsr = {1'b0, tx_empty && !tx_vld_q, tx_empty, 3'b000, oe_q, !rx_empty};

  always_comb begin
    iir = 8'h01;
    if (ier_q[2] && oe_q)           iir = 8'h06;
    else if (ier_q[0] && !rx_empty) iir = 8'h04;
    else if (ier_q[1] && tx_empty)  iir = 8'h02;
  end

  always_comb begin
    rdata = 8'h00;
    if (rd) begin
      case (addr)
        3'd0:    rdata = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
        3'd1:    rdata = {5'b0, ier_q};
        3'd2:    rdata = iir;
        3'd3:    rdata = lcr_q;
        3'd4:    rdata = mcr_q;
        3'd5:    rdata = lsr;
        3'd7:    rdata = scr_q;
        default: rdata = 8'h00;
      endcase
    end
  end
  assign PRDATA = {24'b0, rdata};

  always_comb begin
    tx_wp_d  = tx_flush ? '0 : tx_wp_q + TAW'(tx_push);
    tx_rp_d  = tx_flush ? '0 : tx_rp_q + TAW'(tx_pop);
    tx_cnt_d = tx_flush ? '0 : tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
    rx_wp_d  = rx_flush ? '0 : rx_wp_q + RAW'(rx_push);
    rx_rp_d  = rx_flush ? '0 : rx_rp_q + RAW'(rx_pop);
    rx_cnt_d = rx_flush ? '0 : rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
  end

  // Output register holds until handshake, then idles for TX_GAP cycles before the next load.
  always_comb begin
    tx_vld_d = tx_vld_q;
    tx_dat_d = tx_dat_q;
    gap_d    = gap_q;
    if (tx_pop) begin
      tx_vld_d = 1'b1;
      tx_dat_d = tx_mem_q[tx_rp_q];
    end else if (tx_vld_q && TX_READY) begin
      tx_vld_d = 1'b0;
      gap_d    = GW'(TX_GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_vld_q <= 1'b0;
      tx_dat_q <= 8'h00;
      gap_q    <= '0;
      ier_q    <= 3'b000;
      lcr_q    <= 8'h00;
      mcr_q    <= 8'h00;
      scr_q    <= 8'h00;
      oe_q     <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_vld_q <= tx_vld_d;
      tx_dat_q <= tx_dat_d;
      gap_q    <= gap_d;
      int_q    <= (iir != 8'h01);
      if (oe_set)      oe_q <= 1'b1;
      else if (lsr_rd) oe_q <= 1'b0;
      if (wr && addr == 3'd1) ier_q <= PWDATA[2:0];
      if (wr && addr == 3'd3) lcr_q <= PWDATA[7:0];
      if (wr && addr == 3'd4) mcr_q <= PWDATA[7:0];
      if (wr && addr == 3'd7) scr_q <= PWDATA[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= PWDATA[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= RX_DATA;
  end

  assign TX_VALID = tx_vld_q;
  assign TX_DATA  = tx_dat_q;
  assign INT      = int_q;

  if (SIM_PRINT) begin : g_print
    always_ff @(posedge CLK) begin
      if (RSTN && tx_vld_q && TX_READY) $write("%c", tx_dat_q);
    end
  end
endmodule
